// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port byte memory between an
// instruction-fetch port (A) and a data port (B); three cycles per access.
module mem_arbiter #(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 36
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_req,
    input  logic                    a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [8*BYTE_SIZE-1:0]  a_wd,
    output logic                    a_ack,
    output logic [8*BYTE_SIZE-1:0]  a_rd,
    output logic                    a_err,
    input  logic                    b_req,
    input  logic                    b_we,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [8*BYTE_SIZE-1:0]  b_wd,
    output logic                    b_ack,
    output logic [8*BYTE_SIZE-1:0]  b_rd,
    output logic                    b_err,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [8*BYTE_SIZE-1:0]  mem_wd,
    input  logic [8*BYTE_SIZE-1:0]  mem_rd
);

    localparam int DW = 8 * BYTE_SIZE;
    localparam logic [ADDR_WIDTH:0] SPAN  = (ADDR_WIDTH + 1)'(BYTE_SIZE);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                 state_reg;
    logic                   last_b_reg;
    logic                   sel_b_reg;
    logic                   we_reg;
    logic                   err_reg;
    logic                   mem_we_reg;
    logic [ADDR_WIDTH-1:0]  mem_addr_reg;
    logic [DW-1:0]          mem_wd_reg;
    logic [1:0]             ack_reg;
    logic [1:0]             err_out_reg;
    logic [DW-1:0]          rd_reg [2];

    logic [1:0]             req_vec;
    logic [1:0]             we_vec;
    logic [1:0]             oor_vec;
    logic [ADDR_WIDTH-1:0]  addr_vec [2];
    logic [DW-1:0]          wd_vec [2];
    logic                   grant_b;

    assign req_vec     = {b_req, a_req};
    assign we_vec      = {b_we, a_we};
    assign addr_vec[0] = a_addr;
    assign addr_vec[1] = b_addr;
    assign wd_vec[0]   = a_wd;
    assign wd_vec[1]   = b_wd;

    // Range check one bit wider than the address so addr+BYTE_SIZE cannot wrap.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [ADDR_WIDTH:0] end_addr;
            assign end_addr     = {1'b0, addr_vec[gi]} + SPAN;
            assign oor_vec[gi]  = end_addr > LIMIT;
        end
    endgenerate

    // On a tie the port that did not win the previous tie is granted.
    assign grant_b = req_vec[1] & (~req_vec[0] | ~last_b_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            last_b_reg   <= 1'b1;
            sel_b_reg    <= 1'b0;
            we_reg       <= 1'b0;
            err_reg      <= 1'b0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_wd_reg   <= '0;
            ack_reg      <= '0;
            err_out_reg  <= '0;
            rd_reg[0]    <= '0;
            rd_reg[1]    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= '0;
                    if (|req_vec) begin
                        sel_b_reg    <= grant_b;
                        if (&req_vec)
                            last_b_reg <= grant_b;
                        we_reg       <= we_vec[grant_b];
                        err_reg      <= oor_vec[grant_b];
                        mem_we_reg   <= we_vec[grant_b] & ~oor_vec[grant_b];
                        mem_addr_reg <= addr_vec[grant_b];
                        mem_wd_reg   <= wd_vec[grant_b];
                        state_reg    <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we_reg             <= 1'b0;
                    mem_addr_reg           <= '0;
                    mem_wd_reg             <= '0;
                    rd_reg[sel_b_reg]      <= (~we_reg & ~err_reg) ? mem_rd : '0;
                    err_out_reg[sel_b_reg] <= err_reg;
                    ack_reg[sel_b_reg]     <= 1'b1;
                    state_reg              <= RESP;
                end
                RESP: begin
                    ack_reg   <= '0;
                    state_reg <= IDLE;
                end
                default: begin
                    ack_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Write strobe is gated by reset directly so a reset landing in ACCESS blocks the write.
    assign mem_we   = mem_we_reg & ~reset;
    assign mem_addr = mem_addr_reg;
    assign mem_wd   = mem_wd_reg;

    assign a_ack = ack_reg[0];
    assign b_ack = ack_reg[1];
    assign a_err = err_out_reg[0];
    assign b_err = err_out_reg[1];
    assign a_rd  = rd_reg[0];
    assign b_rd  = rd_reg[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte memory model plus a scoreboard of
// expected responses pushed at issue time and popped on each ack.
module tb_mem_arbiter;

    localparam int BS = 4;
    localparam int AW = 32;
    localparam int MB = 36;
    localparam int DW = 8 * BS;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wd, b_wd;
    logic          a_ack, a_err, b_ack, b_err;
    logic [DW-1:0] a_rd, b_rd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          init_mem;

    logic [7:0]    mem     [MB];
    logic [7:0]    exp_mem [MB];

    typedef struct {
        int            port;
        logic [DW-1:0] rd;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_arbiter #(.BYTE_SIZE(BS), .ADDR_WIDTH(AW), .MEM_BYTES(MB)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wd(a_wd),
        .a_ack(a_ack), .a_rd(a_rd), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wd(b_wd),
        .b_ack(b_ack), .b_rd(b_rd), .b_err(b_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_rd = '0;
        for (int k = 0; k < BS; k++)
            if (longint'(mem_addr) + k < MB)
                mem_rd[8*k +: 8] = mem[int'(mem_addr) + k];
    end

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < MB; i++) mem[i] <= 8'(i + 1);
        end else if (mem_we) begin
            for (int k = 0; k < BS; k++)
                if (longint'(mem_addr) + k < MB)
                    mem[int'(mem_addr) + k] <= mem_wd[8*k +: 8];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic reset_dut();
        reset = 1'b1; init_mem = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wd = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wd = '0;
        for (int i = 0; i < MB; i++) exp_mem[i] = 8'(i + 1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; init_mem = 1'b0;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        a_req = req; a_we = we; a_addr = addr; a_wd = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        b_req = req; b_we = we; b_addr = addr; b_wd = wd;
    endtask

    task automatic push_exp(input int port, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        exp_t e;
        e.port = port;
        e.rd   = '0;
        e.err  = (longint'(addr) + BS > MB);
        if (!e.err)
            for (int k = 0; k < BS; k++)
                if (we) exp_mem[int'(addr) + k] = wd[8*k +: 8];
                else    e.rd[8*k +: 8] = exp_mem[int'(addr) + k];
        sb.push_back(e);
    endtask

    task automatic wait_ack(output int port, output logic [DW-1:0] rd, output logic err,
                            output int lat, output bit timeout, output bit both, output bit we_seen);
        port = -1; rd = '0; err = 1'b0; lat = 0; timeout = 1; both = 0; we_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (mem_we) we_seen = 1;
            if (a_ack && b_ack) both = 1;
            if (a_ack || b_ack) begin
                port = a_ack ? 0 : 1;
                rd   = a_ack ? a_rd : b_rd;
                err  = a_ack ? a_err : b_err;
                lat  = i;
                timeout = 0;
                break;
            end
        end
    endtask

    task automatic pop_exp(output exp_t e, output bit empty);
        empty = (sb.size() == 0);
        e.port = -1; e.rd = '0; e.err = 1'b0;
        if (!empty) e = sb.pop_front();
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++;
        if ({a_ack, b_ack, a_err, b_err} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b required 0000", {a_ack, b_ack, a_err, b_err});
        end
        n_checks++;
        if ({a_rd, b_rd} !== '0) begin
            n_fail++; $display("FAIL reset_rd: got a_rd=%h b_rd=%h required 0", a_rd, b_rd);
        end
        n_checks++;
        if ({mem_we, mem_addr, mem_wd} !== '0) begin
            n_fail++; $display("FAIL reset_mem: got we=%b addr=%h wd=%h required 0", mem_we, mem_addr, mem_wd);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_load_a();
        int port, lat; logic [DW-1:0] rd; logic err; bit to, both, ws, empty; exp_t e;
        set_a(1, 0, 32'd0, '0);
        push_exp(0, 0, 32'd0, '0);
        wait_ack(port, rd, err, lat, to, both, ws);
        set_a(0, 0, '0, '0);
        pop_exp(e, empty);
        n_checks++;
        if (to || empty) begin
            n_fail++; $display("FAIL load_a_ack: timeout=%0d empty=%0d required ack", to, empty);
        end
        n_checks++;
        if (lat !== 2) begin
            n_fail++; $display("FAIL load_a_latency: got %0d required 2", lat);
        end
        n_checks++;
        if (port !== e.port || rd !== e.rd || err !== e.err || rd !== 32'h04030201) begin
            n_fail++; $display("FAIL load_a_data: got port=%0d rd=%h err=%b required port=%0d rd=%h err=%b",
                               port, rd, err, e.port, e.rd, e.err);
        end
        @(posedge clk); #1;
        n_checks++;
        if (a_ack !== 1'b0) begin
            n_fail++; $display("FAIL load_a_pulse: a_ack=%b one cycle after ack required 0", a_ack);
        end
        $display("load_a: port=%0d lat=%0d rd=%h err=%b", port, lat, rd, err);
    endtask

    task automatic test_store_load_b();
        int port, lat; logic [DW-1:0] rd; logic err; bit to, both, ws, empty; exp_t e;
        logic [AW-1:0] addrs [2];
        logic          wes   [2];
        addrs[0] = 32'd8; addrs[1] = 32'd8;
        wes[0]   = 1'b1;  wes[1]   = 1'b0;
        for (int t = 0; t < 2; t++) begin
            set_b(1, wes[t], addrs[t], 32'hDEADBEEF);
            push_exp(1, wes[t], addrs[t], 32'hDEADBEEF);
            wait_ack(port, rd, err, lat, to, both, ws);
            pop_exp(e, empty);
            n_checks++;
            if (to || empty || port !== e.port || rd !== e.rd || err !== e.err) begin
                n_fail++; $display("FAIL b_access%0d: got port=%0d rd=%h err=%b to=%0d required port=%0d rd=%h err=%b",
                                   t, port, rd, err, to, e.port, e.rd, e.err);
            end
            $display("b_access%0d: we=%b addr=%0d rd=%h err=%b", t, wes[t], addrs[t], rd, err);
        end
        set_b(0, 0, '0, '0);
        n_checks++;
        if ({mem[11], mem[10], mem[9], mem[8]} !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL b_store_mem: got %h required deadbeef", {mem[11], mem[10], mem[9], mem[8]});
        end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL b_load_data: got %h required deadbeef", rd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        int port, lat; logic [DW-1:0] rd; logic err; bit to, both, ws, empty; exp_t e;
        logic [AW-1:0] a_list [2];
        logic [AW-1:0] b_list [2];
        int ai, bi, pa, pb;
        bit last_b;
        a_list[0] = 32'd0;  a_list[1] = 32'd4;
        b_list[0] = 32'd12; b_list[1] = 32'd16;
        reset_dut();
        // Model the grant order: ties go to the port that did not win the last tie.
        last_b = 1; pa = 0; pb = 0;
        for (int n = 0; n < 4; n++) begin
            if (pa < 2 && pb < 2) begin
                if (last_b) begin push_exp(0, 0, a_list[pa], '0); pa++; last_b = 0; end
                else        begin push_exp(1, 0, b_list[pb], '0); pb++; last_b = 1; end
            end else if (pa < 2) begin push_exp(0, 0, a_list[pa], '0); pa++; end
            else begin push_exp(1, 0, b_list[pb], '0); pb++; end
        end
        ai = 0; bi = 0;
        set_a(1, 0, a_list[0], '0);
        set_b(1, 0, b_list[0], '0);
        for (int n = 0; n < 4; n++) begin
            wait_ack(port, rd, err, lat, to, both, ws);
            pop_exp(e, empty);
            n_checks++;
            if (to || empty || port !== e.port || rd !== e.rd || err !== e.err) begin
                n_fail++; $display("FAIL contention%0d: got port=%0d rd=%h err=%b to=%0d required port=%0d rd=%h err=%b",
                                   n, port, rd, err, to, e.port, e.rd, e.err);
            end
            n_checks++;
            if (both) begin
                n_fail++; $display("FAIL contention_both%0d: both acks high required at most one", n);
            end
            n_checks++;
            if (port !== (n % 2)) begin
                n_fail++; $display("FAIL contention_order%0d: got port %0d required %0d", n, port, n % 2);
            end
            $display("contention%0d: port=%0d rd=%h err=%b", n, port, rd, err);
            if (port == 0) begin
                ai++;
                if (ai < 2) set_a(1, 0, a_list[ai], '0); else set_a(0, 0, '0, '0);
            end else if (port == 1) begin
                bi++;
                if (bi < 2) set_b(1, 0, b_list[bi], '0); else set_b(0, 0, '0, '0);
            end
            @(posedge clk); #1;
            n_checks++;
            if (a_ack || b_ack) begin
                n_fail++; $display("FAIL contention_pulse%0d: a_ack=%b b_ack=%b required 0", n, a_ack, b_ack);
            end
        end
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
    endtask

    task automatic test_range_stores();
        int port, lat; logic [DW-1:0] rd; logic err; bit to, both, ws, empty; exp_t e;
        logic [AW-1:0] addrs [2];
        logic [DW-1:0] wds   [2];
        logic [31:0]   snap;
        addrs[0] = 32'd33; wds[0] = 32'h12345678;
        addrs[1] = 32'd32; wds[1] = 32'hA5A51234;
        for (int t = 0; t < 2; t++) begin
            snap = {exp_mem[35], exp_mem[34], exp_mem[33], exp_mem[32]};
            set_b(1, 1, addrs[t], wds[t]);
            push_exp(1, 1, addrs[t], wds[t]);
            wait_ack(port, rd, err, lat, to, both, ws);
            set_b(0, 0, '0, '0);
            pop_exp(e, empty);
            n_checks++;
            if (to || empty || err !== e.err || rd !== e.rd || err !== (t == 0)) begin
                n_fail++; $display("FAIL range_store%0d: got rd=%h err=%b to=%0d required rd=%h err=%b",
                                   t, rd, err, to, e.rd, e.err);
            end
            n_checks++;
            if (ws !== (t == 1)) begin
                n_fail++; $display("FAIL range_we%0d: mem_we seen=%0d required %0d", t, ws, (t == 1));
            end
            @(posedge clk); #1;
            n_checks++;
            if ({mem[35], mem[34], mem[33], mem[32]} !== {exp_mem[35], exp_mem[34], exp_mem[33], exp_mem[32]}) begin
                n_fail++; $display("FAIL range_mem%0d: got %h required %h (before %h)", t,
                                   {mem[35], mem[34], mem[33], mem[32]},
                                   {exp_mem[35], exp_mem[34], exp_mem[33], exp_mem[32]}, snap);
            end
            $display("range_store%0d: addr=%0d err=%b we_seen=%0d", t, addrs[t], err, ws);
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        set_a(1, 1, 32'd4, 32'hCAFEF00D);
        @(posedge clk); #1;
        n_checks++;
        if (mem_we !== 1'b1) begin
            n_fail++; $display("FAIL mid_access_we: mem_we=%b in ACCESS required 1", mem_we);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (mem_we !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_we: mem_we=%b during reset required 0", mem_we);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        set_a(0, 0, '0, '0);
        n_checks++;
        if ({a_ack, a_err, a_rd, mem_addr} !== '0) begin
            n_fail++; $display("FAIL mid_reset_clear: a_ack=%b a_err=%b a_rd=%h mem_addr=%h required 0",
                               a_ack, a_err, a_rd, mem_addr);
        end
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (a_ack) acks++;
        end
        n_checks++;
        if (acks !== 0) begin
            n_fail++; $display("FAIL mid_reset_ack: a_ack pulsed %0d times required 0", acks);
        end
        n_checks++;
        if ({mem[7], mem[6], mem[5], mem[4]} !== {exp_mem[7], exp_mem[6], exp_mem[5], exp_mem[4]}) begin
            n_fail++; $display("FAIL mid_reset_mem: got %h required %h",
                               {mem[7], mem[6], mem[5], mem[4]}, {exp_mem[7], exp_mem[6], exp_mem[5], exp_mem[4]});
        end
        $display("reset_mid: acks=%0d mem[4..7]=%h", acks, {mem[7], mem[6], mem[5], mem[4]});
    endtask

    initial begin
        test_reset();
        test_load_a();
        test_store_load_b();
        test_contention();
        test_range_stores();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
